spi_flash_reader: RTL and testbench
===================================

# spi_flash_reader

Responder side of the CPU's SPI read handshake. When the core raises `spi_enable`, the block fetches one 32-bit word from an external SPI NOR flash and answers with `spi_ack` plus `spi_data`. It sits beside the CPU top, and its ports feed the core's `spi_ack` and `spi_data` inputs directly. It is the SPI mode-0 master on the board pins, issuing a standard READ (0x03) command.

## Interface
- `CLK_DIV`, default 2: `clk` cycles per SCLK half-period; legal range ≥1.
- `READ_CMD`, default 8'h03: flash read opcode.
- `clk`  in  1: system clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-low; `reset==0` at a rising edge resets the block.
- `spi_enable`  in  1: request from the core, level; held until ack is seen.
- `spi_addr`  in  24: flash byte address; latched when the request is accepted.
- `spi_ack`  out  1: transfer complete; `spi_data` is valid while high.
- `spi_data`  out  32: assembled read word.
- `spi_sclk`  out  1: SPI clock; idles low.
- `spi_cs_n`  out  1: chip select, active-low.
- `spi_mosi`  out  1: master out.
- `spi_miso`  in  1: master in; synchronise it in a 2-flop chain before use.

## Operation
- Reset values: `spi_ack`=0, `spi_data`=0, `spi_sclk`=0, `spi_cs_n`=1, `spi_mosi`=0, state=IDLE, counters=0.
- Four-phase handshake:
  - The core raises `spi_enable`.
  - The block raises `spi_ack` when the transfer is done.
  - The core drops `spi_enable`.
  - The block drops `spi_ack` on the next edge.
  - A new request is accepted only in IDLE with `spi_ack`=0.
- States:
  - IDLE: if `spi_enable`=1, latch the shift-out register as {`READ_CMD`, `spi_addr`}, drive `cs_n`=0, go to SETUP.
  - SETUP: wait one half-period (CLK_DIV cycles), with `mosi` = bit 31 of the shift-out register. Then go to SHIFT.
  - SHIFT: run 64 SCLK periods.
    - Bits 0–31 send command and address MSB-first.
    - Bits 32–63 sample MISO into the shift-in register, MSB-first.
    - SCLK rises after each low half-period; MISO is sampled on the rising edge.
    - SCLK falls after the high half-period; MOSI shifts on the falling edge.
    - After the 64th falling edge, go to HOLD.
  - HOLD: SCLK low for one half-period (CLK_DIV cycles). Then `cs_n`=1, load `spi_data` from the shift-in register, `spi_ack`=1, go to ACK.
  - ACK: hold `spi_ack`=1 until `spi_enable`=0. Then `spi_ack`=0, go to IDLE.
- Abort: if `spi_enable`=0 in SETUP, SHIFT or HOLD, then on the next edge:
  - `cs_n`=1, `sclk`=0, state=IDLE.
  - `spi_ack` stays 0 and `spi_data` is unchanged.
- `mosi` is 0 while `cs_n`=1 and during the data phase (bits 32–63).
- Bit counter is 6 bits and counts 0..63 with no wrap; the terminal value 63 moves to HOLD.
- Divider counter counts 0..CLK_DIV−1 and reloads on every half-period boundary.
- Reset mid-transfer forces the reset values on that edge, with no partial ack.

## Timing
- `cs_n` falls 1 cycle after the edge that samples `spi_enable`=1 in IDLE.
- `spi_ack` rises exactly 130·CLK_DIV+1 cycles after that sampling edge; with CLK_DIV=2 that is 261 cycles.
- `spi_ack` falls 1 cycle after `spi_enable`=0 is sampled in ACK.
- Throughput is one word per 130·CLK_DIV+3 cycles minimum, including the handshake.
- MISO path latency: the 2-flop synchroniser delays sampling by 2 cycles. With CLK_DIV≥3, sampling lands inside the high half-period. With CLK_DIV<3, the flash must be fast enough; this is documented as a board constraint.

## Configuration
- `SPI_BYTE_SWAP_EN`:
  - Defined: `spi_data` is byte-reversed, so the byte at `spi_addr` lands in [7:0] (little-endian word, matching RV32 loads).
  - Undefined: the first received byte lands in [31:24] (raw shift order).

## Structure
- Shared package `spi_pkg`:
  - `spi_state_t` enum (IDLE, SETUP, SHIFT, HOLD, ACK).
  - `SPI_BITS`=64 and `SPI_ADDR_W`=24 constants.
  - `READ_CMD` default value.
- One sub-module, `spi_clk_div`: holds the divider counter and outputs single-cycle `rise_tick`/`fall_tick` strobes plus an `sclk` level. It is enabled only in SHIFT.
- Shift registers, bit counter, handshake and FSM live in the top.

## Test plan
- Basic read:
  - Stimulus: CLK_DIV=2, `spi_addr`=24'h000100, flash model returns bytes DE AD BE EF.
  - Response: MOSI stream 03 00 01 00; `spi_ack` at cycle 261.
  - `spi_data`=32'hDEADBEEF without the macro, 32'hEFBEADDE with `SPI_BYTE_SWAP_EN`.
- Handshake:
  - Stimulus: hold `spi_enable` for 10 cycles after ack.
  - Response: `spi_ack` stays 1 and `spi_data` is stable. Drop `spi_enable`; `spi_ack`=0 next cycle. Re-raising it starts a new transfer.
- Abort:
  - Stimulus: drop `spi_enable` at SCLK period 20.
  - Response: next cycle `cs_n`=1 and `sclk`=0; no ack; `spi_data` keeps its previous value.
- Reset mid-transfer:
  - Stimulus: `reset`=0 for 1 cycle during the data phase.
  - Response: all outputs at reset values on that edge. A following request completes normally.
- Divider extremes:
  - Stimulus: CLK_DIV=1 and CLK_DIV=5.
  - Response: exactly 64 SCLK rising edges per transfer; ack latency 131 and 651 cycles respectively.
- Back-to-back transfers:
  - Stimulus: two reads at addresses 24'hFFFFFC then 24'h000000.
  - Response: correct addresses on MOSI and correct data for each transfer; `cs_n` high for ≥2 cycles between them.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI NOR read responder.
// Latency: none (types only).
// Backpressure: not applicable; byte order is chosen in the top via SPI_BYTE_SWAP_EN.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        ACK
    } spi_state_t;

    localparam int         SPI_BITS     = 64;
    localparam int         SPI_ADDR_W   = 24;
    localparam logic [7:0] SPI_READ_CMD = 8'h03;

    // Reverse byte order so the first byte read from flash ends up in [7:0].
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: half-period divider producing an sclk level and rise/fall strobes.
// Latency: first rise_tick CLK_DIV cycles after en goes high; strobes last one cycle.
// Backpressure: none; dropping en clears the counter and forces sclk low on the next edge.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick,
    output logic sclk
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          boundary;

    assign boundary  = en && (cnt == CW'(CLK_DIV - 1));
    assign rise_tick = boundary && !sclk;
    assign fall_tick = boundary && sclk;

    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (boundary) begin
            cnt  <= '0;
            sclk <= !sclk;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI NOR word fetcher: READ cmd + 24-bit address, 32 data bits, mode 0; SPI_BYTE_SWAP_EN selects little-endian word.
// Latency: spi_ack rises 130*CLK_DIV+1 cycles after the request is accepted; falls 1 cycle after spi_enable drops.
// Backpressure: four-phase level handshake; requests taken only in IDLE with spi_ack low; spi_enable low mid-transfer aborts.
module spi_flash_reader
    import spi_pkg::*;
#(
    parameter int         CLK_DIV  = 2,
    parameter logic [7:0] READ_CMD = SPI_READ_CMD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_enable,
    input  logic [SPI_ADDR_W-1:0] spi_addr,
    output logic                  spi_ack,
    output logic [31:0]           spi_data,
    output logic                  spi_sclk,
    output logic                  spi_cs_n,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);
    localparam int         PW       = $clog2(CLK_DIV + 1);
    localparam logic [5:0] LAST_BIT = 6'(SPI_BITS - 1);
    localparam logic [5:0] DATA_BIT = 6'(SPI_BITS / 2);

    spi_state_t    state;
    spi_state_t    state_nxt;
    logic [PW-1:0] phase_cnt;
    logic [5:0]    bit_cnt;
    logic [31:0]   shift_out;
    logic [31:0]   shift_in;
    logic [31:0]   rx_word;
    logic          miso_s1;
    logic          miso_s2;
    logic          div_en;
    logic          rise_tick;
    logic          fall_tick;
    logic          data_phase;

    assign div_en     = (state == SHIFT) && spi_enable;
    assign data_phase = (bit_cnt >= DATA_BIT);
    assign spi_mosi   = !spi_cs_n && !data_phase && shift_out[31];

`ifdef SPI_BYTE_SWAP_EN
    assign rx_word = byte_swap32(shift_in);
`else
    assign rx_word = shift_in;
`endif

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk      (clk),
        .reset    (reset),
        .en       (div_en),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick),
        .sclk     (spi_sclk)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (spi_enable && !spi_ack) state_nxt = SETUP;
            SETUP: begin
                if (!spi_enable)                            state_nxt = IDLE;
                else if (phase_cnt == PW'(CLK_DIV - 1))     state_nxt = SHIFT;
            end
            SHIFT: begin
                if (!spi_enable)                            state_nxt = IDLE;
                else if (fall_tick && bit_cnt == LAST_BIT)  state_nxt = HOLD;
            end
            // HOLD runs one cycle past the low half-period so ack lands 130*CLK_DIV+1 after accept.
            HOLD: begin
                if (!spi_enable)                            state_nxt = IDLE;
                else if (phase_cnt == PW'(CLK_DIV))         state_nxt = ACK;
            end
            ACK:   if (!spi_enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            shift_out <= '0;
            shift_in  <= '0;
            miso_s1   <= 1'b0;
            miso_s2   <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_ack   <= 1'b0;
            spi_data  <= '0;
        end else begin
            state   <= state_nxt;
            miso_s1 <= spi_miso;
            miso_s2 <= miso_s1;

            if (state_nxt == state && (state == SETUP || state == HOLD))
                phase_cnt <= phase_cnt + PW'(1);
            else
                phase_cnt <= '0;

            case (state)
                IDLE: begin
                    if (state_nxt == SETUP) begin
                        shift_out <= {READ_CMD, spi_addr};
                        shift_in  <= '0;
                        bit_cnt   <= '0;
                        spi_cs_n  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (rise_tick && data_phase)
                        shift_in <= {shift_in[30:0], miso_s2};
                    if (fall_tick) begin
                        shift_out <= {shift_out[30:0], 1'b0};
                        if (bit_cnt != LAST_BIT)
                            bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                HOLD: begin
                    if (state_nxt == ACK) begin
                        spi_cs_n <= 1'b1;
                        spi_ack  <= 1'b1;
                        spi_data <= rx_word;
                    end
                end
                ACK: begin
                    if (!spi_enable)
                        spi_ack <= 1'b0;
                end
                default: ;
            endcase

            // Any return to IDLE (completion or abort) releases the bus; spi_data is left alone.
            if (state_nxt == IDLE && state != IDLE) begin
                spi_cs_n <= 1'b1;
                bit_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Randomized bench for spi_flash_reader at CLK_DIV = 2, 1 and 5 with a scoreboard per instance.
`timescale 1ns/1ps
module tb_spi_flash_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] cmd_word;
        logic [31:0] data;
    } exp_t;

    // Flash contents: fixed pattern at 0x100, address hash elsewhere.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'hDE;
            24'h000101: return 8'hAD;
            24'h000102: return 8'hBE;
            24'h000103: return 8'hEF;
            default:    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        return {flash_byte(a), flash_byte(a + 24'd1), flash_byte(a + 24'd2), flash_byte(a + 24'd3)};
    endfunction

    function automatic logic [31:0] expect_data(input logic [23:0] a);
`ifdef SPI_BYTE_SWAP_EN
        return {flash_byte(a + 24'd3), flash_byte(a + 24'd2), flash_byte(a + 24'd1), flash_byte(a)};
`else
        return flash_word(a);
`endif
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (CLK_DIV=%0d): got %0h, want %0h", name, d, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_div
        localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

        logic        reset;
        logic        spi_enable;
        logic [23:0] spi_addr;
        logic        spi_ack;
        logic [31:0] spi_data;
        logic        spi_sclk;
        logic        spi_cs_n;
        logic        spi_mosi;
        logic        spi_miso;
        logic [23:0] cur_addr;
        logic [31:0] last_data;
        logic        done_g;
        exp_t        sb_q[$];

        spi_flash_reader #(.CLK_DIV(D)) dut (
            .clk       (clk),
            .reset     (reset),
            .spi_enable(spi_enable),
            .spi_addr  (spi_addr),
            .spi_ack   (spi_ack),
            .spi_data  (spi_data),
            .spi_sclk  (spi_sclk),
            .spi_cs_n  (spi_cs_n),
            .spi_mosi  (spi_mosi),
            .spi_miso  (spi_miso)
        );

        // Fast flash: SCLK period p rises (2p+2)*D cycles after accept and the
        // 2-flop synchroniser looks 2 cycles back, so each data bit is put out 3 cycles early.
        initial begin
            int n;
            int p;
            logic [31:0] w;
            spi_miso = 1'b0;
            n = -1;
            w = '0;
            forever begin
                @(negedge clk);
                if (spi_cs_n === 1'b1) begin
                    n = -1;
                    spi_miso = 1'b0;
                end else begin
                    if (n < 0) w = flash_word(cur_addr);
                    n++;
                    p = (n + 3) / (2 * D) - 1;
                    spi_miso = (p >= 32 && p < 64) ? w[63 - p] : 1'b0;
                end
            end
        end

        // Monitor: records MOSI, SCLK rises, latency; checks against the scoreboard on each ack.
        initial begin
            int lat;
            int rises;
            int gap;
            logic [31:0] mosi_w;
            logic sclk_p;
            logic cs_p;
            logic ack_p;
            exp_t e;
            lat = 0; rises = 0; gap = 0; mosi_w = '0;
            sclk_p = 1'b0; cs_p = 1'b1; ack_p = 1'b0;
            forever begin
                @(negedge clk);
                if (spi_cs_n === 1'b0 && cs_p === 1'b1) begin
                    chk("cs_n_high_gap_ge2", D, 64'(gap >= 2), 64'd1);
                    lat = 0;
                    rises = 0;
                    mosi_w = '0;
                end else begin
                    lat++;
                end
                gap = (spi_cs_n === 1'b1) ? gap + 1 : 0;
                if (spi_sclk === 1'b1 && sclk_p === 1'b0) begin
                    if (rises < 32) mosi_w = {mosi_w[30:0], spi_mosi};
                    rises++;
                end
                if (spi_ack === 1'b1 && ack_p === 1'b0) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_ack", D, 64'(spi_ack), 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("data", D, 64'(spi_data), 64'(e.data));
                        chk("mosi_cmd_addr", D, 64'(mosi_w), 64'(e.cmd_word));
                        chk("sclk_rises", D, 64'(rises), 64'd64);
                        chk("ack_latency", D, 64'(lat), 64'(130 * D + 1));
                    end
                end
                sclk_p = spi_sclk;
                cs_p   = spi_cs_n;
                ack_p  = spi_ack;
            end
        end

        task automatic chk_reset_outputs();
            chk("rst_ack",  D, 64'(spi_ack),  64'd0);
            chk("rst_data", D, 64'(spi_data), 64'd0);
            chk("rst_sclk", D, 64'(spi_sclk), 64'd0);
            chk("rst_cs_n", D, 64'(spi_cs_n), 64'd1);
            chk("rst_mosi", D, 64'(spi_mosi), 64'd0);
        endtask

        task automatic do_read(input logic [23:0] a, input int hold);
            exp_t e;
            bit ok;
            e.cmd_word = {8'h03, a};
            e.data     = expect_data(a);
            spi_addr   = a;
            cur_addr   = a;
            sb_q.push_back(e);
            spi_enable = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 130 * D + 20; i++) begin
                @(negedge clk);
                if (spi_ack === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("ack_within_budget", D, 64'(ok), 64'd1);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("ack_held", D, 64'(spi_ack), 64'd1);
                chk("data_stable", D, 64'(spi_data), 64'(e.data));
            end
            spi_enable = 1'b0;
            @(negedge clk);
            chk("ack_drop", D, 64'(spi_ack), 64'd0);
            last_data = e.data;
        endtask

        // Start a request, then abort it (or reset) after stop_rises SCLK rises.
        task automatic partial(input int stop_rises, input bit use_reset);
            int r;
            logic sp;
            spi_addr   = 24'($urandom);
            cur_addr   = spi_addr;
            spi_enable = 1'b1;
            r = 0;
            sp = 1'b0;
            for (int i = 0; i < 200 * D && r < stop_rises; i++) begin
                @(negedge clk);
                if (spi_sclk === 1'b1 && sp === 1'b0) r++;
                sp = spi_sclk;
            end
            chk("reached_sclk_period", D, 64'(r), 64'(stop_rises));
            spi_enable = 1'b0;
            if (use_reset) reset = 1'b0;
            @(negedge clk);
            if (use_reset) begin
                chk_reset_outputs();
                last_data = '0;
                reset = 1'b1;
            end else begin
                chk("abort_cs_n", D, 64'(spi_cs_n), 64'd1);
                chk("abort_sclk", D, 64'(spi_sclk), 64'd0);
                chk("abort_no_ack", D, 64'(spi_ack), 64'd0);
                chk("abort_data_kept", D, 64'(spi_data), 64'(last_data));
            end
            repeat (3) @(negedge clk);
            chk("still_no_ack", D, 64'(spi_ack), 64'd0);
        endtask

        initial begin
            done_g = 1'b0;
            reset = 1'b0;
            spi_enable = 1'b0;
            spi_addr = '0;
            cur_addr = '0;
            last_data = '0;
            repeat (3) @(negedge clk);
            chk_reset_outputs();
            reset = 1'b1;
            @(negedge clk);
            do_read(24'h000100, 0);
            repeat (2) @(negedge clk);
            do_read(24'($urandom), 10);
            do_read(24'($urandom), 0);
            repeat (2) @(negedge clk);
            partial(20, 1'b0);
            partial(40, 1'b1);
            do_read(24'($urandom), 0);
            repeat (3) @(negedge clk);
            do_read(24'hFFFFFC, 0);
            do_read(24'h000000, 0);
            for (int k = 0; k < 3; k++) begin
                repeat ($urandom_range(3, 0)) @(negedge clk);
                do_read(24'($urandom), int'($urandom_range(3, 0)));
            end
            repeat (4) @(negedge clk);
            chk("scoreboard_drained", D, 64'(sb_q.size()), 64'd0);
            done_g = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int i = 0; i < 20000 && !all_done; i++) begin
            @(negedge clk);
            all_done = gen_div[0].done_g && gen_div[1].done_g && gen_div[2].done_g;
        end
        if (!all_done) begin
            failures++;
            $display("FAIL run_timeout: got done=%b%b%b, want 111",
                     gen_div[0].done_g, gen_div[1].done_g, gen_div[2].done_g);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
